dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline MEM stage (CPU requester) and a debug/loader port (DBG requester) that loads programs and inspects memory.
- Sits between the EX/MEM pipeline register and the data memory.
- Drives a stall that freezes PC, IF/ID, ID/EX and EX/MEM while a CPU access is outstanding.
- CPU has priority, with a starvation guard that forces a DBG grant after repeated losses, and a timeout guard so a missing memory response cannot hang the pipeline.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/sat_counter.sv | 31 +++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs, default widths.
// No logic; imported by the arbiter.
// No flow control of its own.
package pipeline_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        DBG_WAIT = 2'd2,
        DBG_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags cnt == LIMIT.
// Latency: count updates one cycle after inc/clr; at_limit is combinational on the count.
// No backpressure: clr wins over inc, inc is ignored once saturated.
module sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and the debug/loader port.
// Latency: grant cycle + >=1 wait cycle; CPU load data is combinational in the completion cycle.
// Backpressure: cpu_stall freezes the pipeline; dbg_req is held until the dbg_ack pulse.
module dmem_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = pipeline_pkg::ADDR_W,
    parameter int DATA_W      = pipeline_pkg::DATA_W,
    parameter int MAX_WAIT    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    localparam int STARVE_W = $clog2(MAX_WAIT + 1);
    localparam int WAIT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    arb_state_t state, state_nxt;

    logic              in_cpu_wait, in_dbg_wait, in_wait;
    logic              wait_at_limit, starve_at_limit;
    logic              completing, timeout;
    logic              grant_cpu, grant_dbg, owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] comp_data;
    logic [DATA_W-1:0] cpu_rdata_q;

    assign in_cpu_wait = (state == CPU_WAIT);
    assign in_dbg_wait = (state == DBG_WAIT);
    assign in_wait     = in_cpu_wait | in_dbg_wait;

    // A timed-out access completes in the same cycle the counter hits its limit.
    assign completing = in_wait & (mem_rvalid | wait_at_limit);
    assign timeout    = in_wait & ~mem_rvalid & wait_at_limit;
    assign comp_data  = mem_rvalid ? mem_rdata : '0;

    // DBG_DONE still sees the old dbg_req, so debug may only win from IDLE.
    assign grant_dbg = (state == IDLE) & dbg_req & (~cpu_req | starve_at_limit);
    assign grant_cpu = ((state == IDLE) | (state == DBG_DONE)) & cpu_req & ~grant_dbg;

    assign owner     = grant_dbg ? REQ_DBG : REQ_CPU;
    assign sel_we    = (owner == REQ_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (owner == REQ_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (owner == REQ_DBG) ? dbg_wdata : cpu_wdata;

    sat_counter #(
        .W     (STARVE_W),
        .LIMIT (MAX_WAIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (grant_cpu & dbg_req & (state == IDLE)),
        .clr      (grant_dbg),
        .at_limit (starve_at_limit)
    );

    sat_counter #(
        .W     (WAIT_W),
        .LIMIT (MEM_TIMEOUT - 1)
    ) u_wait (
        .clock    (clock),
        .reset    (reset),
        .inc      (in_wait & ~mem_rvalid),
        .clr      (~in_wait | completing),
        .at_limit (wait_at_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DBG_DONE: begin
                if (grant_dbg) begin
                    state_nxt = DBG_WAIT;
                end else if (grant_cpu) begin
                    state_nxt = CPU_WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CPU_WAIT: if (completing) state_nxt = IDLE;
            DBG_WAIT: if (completing) state_nxt = DBG_DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata   <= '0;
            mem_err     <= 1'b0;
        end else begin
            mem_req <= grant_cpu | grant_dbg;
            if (grant_cpu | grant_dbg) begin
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (in_cpu_wait & completing) begin
                cpu_rdata_q <= comp_data;
            end
            if (in_dbg_wait & completing) begin
                dbg_rdata <= comp_data;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign cpu_rdata = (in_cpu_wait & completing) ? comp_data : cpu_rdata_q;
    assign cpu_stall = reset & cpu_req & ~(in_cpu_wait & completing);
    assign dbg_ack   = (state == DBG_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, CPU load/store latency, debug read,
// starvation guard, timeout and reset mid-access.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_rvalid;
    logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic [63:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, dbg_ack, mem_req, mem_we, mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .MAX_WAIT    (4),
        .MEM_TIMEOUT (16)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [63:0] grant_addr [$];
    int          ack_cnt;
    int          stall_cnt;
    logic        drop_dbg;

    initial begin
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        // ---------------- reset state ----------------
        cyc(); cyc();
        settle();
        chk("rst_stall_forced0", 64'(cpu_stall), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_dbg_rdata", dbg_rdata, 64'd0);
        chk("rst_dbg_ack", 64'(dbg_ack), 64'd0);
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        cpu_req = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        // ---------------- CPU load, latency 1 ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h40;
        settle();
        chk("ld1_grant_stall", 64'(cpu_stall), 64'd1);
        chk("ld1_grant_noreq", 64'(mem_req), 64'd0);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        settle();
        chk("ld1_mem_req", 64'(mem_req), 64'd1);
        chk("ld1_mem_addr", mem_addr, 64'h40);
        chk("ld1_mem_we", 64'(mem_we), 64'd0);
        chk("ld1_unstall", 64'(cpu_stall), 64'd0);
        chk("ld1_rdata_comb", cpu_rdata, 64'hDEAD_BEEF);
        cyc();
        cpu_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h999;
        settle();
        chk("ld1_rdata_hold", cpu_rdata, 64'hDEAD_BEEF);
        chk("ld1_idle_req", 64'(mem_req), 64'd0);

        // ---------------- CPU store, 3-cycle stall ----------------
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h80; cpu_wdata = 64'h1234;
        settle();
        chk("st_grant_stall", 64'(cpu_stall), 64'd1);
        cyc();
        cpu_addr = 64'hFFFF; cpu_wdata = 64'hFFFF;
        settle();
        chk("st_w1_req", 64'(mem_req), 64'd1);
        chk("st_w1_we", 64'(mem_we), 64'd1);
        chk("st_w1_addr", mem_addr, 64'h80);
        chk("st_w1_wdata", mem_wdata, 64'h1234);
        chk("st_w1_stall", 64'(cpu_stall), 64'd1);
        cyc();
        settle();
        chk("st_w2_req", 64'(mem_req), 64'd0);
        chk("st_w2_we", 64'(mem_we), 64'd1);
        chk("st_w2_addr", mem_addr, 64'h80);
        chk("st_w2_wdata", mem_wdata, 64'h1234);
        chk("st_w2_stall", 64'(cpu_stall), 64'd1);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 64'h77;
        settle();
        chk("st_w3_addr", mem_addr, 64'h80);
        chk("st_w3_wdata", mem_wdata, 64'h1234);
        chk("st_w3_unstall", 64'(cpu_stall), 64'd0);
        cyc();
        cpu_req = 1'b0; mem_rdata = 64'hBAD;
        settle();
        chk("stray_rvalid_rdata", cpu_rdata, 64'h77);
        chk("stray_rvalid_ack", 64'(dbg_ack), 64'd0);
        cyc();
        mem_rvalid = 1'b0;
        settle();
        chk("stray_rvalid_noreq", 64'(mem_req), 64'd0);

        // ---------------- DBG read ----------------
        cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h8;
        settle();
        chk("dbg_idle_ack", 64'(dbg_ack), 64'd0);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 64'h55;
        settle();
        chk("dbg_mem_req", 64'(mem_req), 64'd1);
        chk("dbg_mem_addr", mem_addr, 64'h8);
        chk("dbg_mem_we", 64'(mem_we), 64'd0);
        chk("dbg_wait_ack", 64'(dbg_ack), 64'd0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 64'h0;
        settle();
        chk("dbg_ack_pulse", 64'(dbg_ack), 64'd1);
        chk("dbg_rdata", dbg_rdata, 64'h55);
        cyc();
        dbg_req = 1'b0;
        settle();
        chk("dbg_ack_once", 64'(dbg_ack), 64'd0);
        chk("dbg_no_regrant", 64'(mem_req), 64'd0);
        cyc();
        settle();
        chk("dbg_no_regrant2", 64'(mem_req), 64'd0);
        chk("dbg_rdata_hold", dbg_rdata, 64'h55);

        // ---------------- starvation guard ----------------
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h200; dbg_wdata = 64'hAA;
        mem_rvalid = 1'b1; mem_rdata = 64'h11;
        ack_cnt = 0;
        drop_dbg = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i != 0) cyc();
            if (drop_dbg) dbg_req = 1'b0;
            settle();
            if (mem_req) grant_addr.push_back(mem_addr);
            if (mem_req && mem_addr == 64'h200) begin
                chk("starve_dbg_we", 64'(mem_we), 64'd1);
                chk("starve_dbg_wdata", mem_wdata, 64'hAA);
            end
            if (dbg_ack) begin
                ack_cnt++;
                drop_dbg = 1'b1;
            end
        end
        chk("starve_grants", 64'(grant_addr.size()), 64'd7);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_addr.size())
                chk($sformatf("starve_grant%0d", i), grant_addr[i], (i == 4) ? 64'h200 : 64'h100);
        end
        chk("starve_ack_cnt", 64'(ack_cnt), 64'd1);
        chk("starve_cnt_clear", 64'(u_dut.u_starve.at_limit), 64'd0);
        cyc();
        cpu_req = 1'b0; mem_rvalid = 1'b0;
        cyc();
        settle();
        chk("starve_end_idle", 64'(mem_req), 64'd0);

        // ---------------- timeout ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h300; mem_rdata = 64'hFFFF;
        settle();
        chk("to_grant_stall", 64'(cpu_stall), 64'd1);
        stall_cnt = 1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            settle();
            if (cpu_stall) stall_cnt++;
            chk($sformatf("to_err_pre%0d", i), 64'(mem_err), 64'd0);
        end
        chk("to_stall_cycles", 64'(stall_cnt), 64'd16);
        chk("to_rdata_zero", cpu_rdata, 64'd0);
        cyc();
        cpu_req = 1'b0;
        settle();
        chk("to_err_set", 64'(mem_err), 64'd1);
        chk("to_rdata_hold", cpu_rdata, 64'd0);
        chk("to_idle_req", 64'(mem_req), 64'd0);
        cyc(); cyc();
        settle();
        chk("to_err_sticky", 64'(mem_err), 64'd1);

        // ---------------- reset mid-access ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h500; mem_rdata = 64'h0;
        cyc();
        settle();
        chk("rma_req", 64'(mem_req), 64'd1);
        reset = 1'b0;
        settle();
        chk("rma_req_cleared", 64'(mem_req), 64'd0);
        chk("rma_stall", 64'(cpu_stall), 64'd0);
        chk("rma_err_cleared", 64'(mem_err), 64'd0);
        chk("rma_addr_cleared", mem_addr, 64'd0);
        cyc();
        reset = 1'b1; cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hABC;
        settle();
        chk("rma_late_req", 64'(mem_req), 64'd0);
        chk("rma_late_stall", 64'(cpu_stall), 64'd0);
        chk("rma_late_rdata", cpu_rdata, 64'd0);
        chk("rma_late_ack", 64'(dbg_ack), 64'd0);
        cyc();
        mem_rvalid = 1'b0;
        settle();
        chk("rma_no_capture", cpu_rdata, 64'd0);
        chk("rma_idle", 64'(mem_req), 64'd0);
        chk("rma_err", 64'(mem_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
